// File: rtl/noc_traffic_source.sv
// Synthetic NoC traffic injector: probabilistically creates flits, queues them in a small
// FIFO and delivers them over valid/ready, keeping saturating sent/dropped statistics.
module noc_traffic_source #(
    parameter int unsigned ADDR_BITS     = 4,
    parameter int unsigned SRC_ADDR      = 0,
    parameter int unsigned INJ_THRESHOLD = 32,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     send_i,
    input  logic [31:0]              rand_i,
    output logic [2*ADDR_BITS+7:0]   out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     busy_o,
    output logic [CNT_BITS-1:0]      sent_count_o,
    output logic [CNT_BITS-1:0]      dropped_count_o
);

    localparam int unsigned FlitW = 2 * ADDR_BITS + 8;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;

    localparam logic [8:0]           Thr  = 9'(INJ_THRESHOLD);
    localparam logic [ADDR_BITS-1:0] Src  = ADDR_BITS'(SRC_ADDR);
    localparam logic [OccW-1:0]      Full = OccW'(FIFO_DEPTH);

    logic [1:0]          state_q, state_d;
    logic [FlitW-1:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [OccW-1:0]     occ_q, occ_d;
    logic [7:0]          seq_q;
    logic [CNT_BITS-1:0] sent_q, dropped_q;

    logic                 gen, push, pop, drop, full;
    logic [ADDR_BITS-1:0] dest_raw, dest;
    logic [FlitW-1:0]     flit;

    logic unused_rand;
    assign unused_rand = ^rand_i[31:ADDR_BITS+8];

    always_comb begin
        full     = (occ_q == Full);
        pop      = (occ_q != '0) && out_ready_i;
        gen      = (state_q == StActive) && send_i && ({1'b0, rand_i[7:0]} < Thr);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push     = gen && (!full || pop);
        drop     = gen && full && !pop;
        dest_raw = rand_i[ADDR_BITS+7:8];
        dest     = (dest_raw == Src) ? dest_raw + ADDR_BITS'(1) : dest_raw;
        flit     = {dest, Src, seq_q};
        occ_d    = occ_q + OccW'(push) - OccW'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (send_i) state_d = StActive;
            end
            StActive: begin
                if (!send_i) state_d = (occ_q != '0) ? StDrain : StIdle;
            end
            StDrain: begin
                if (send_i) state_d = StActive;
                else if (occ_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            seq_q     <= '0;
            sent_q    <= '0;
            dropped_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= flit;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (gen) seq_q <= seq_q + 8'd1;
            if (pop && sent_q != '1) sent_q <= sent_q + CNT_BITS'(1);
            if (drop && dropped_q != '1) dropped_q <= dropped_q + CNT_BITS'(1);
        end
    end

    assign out_data_o      = mem_q[rd_ptr_q];
    assign out_valid_o     = (occ_q != '0);
    assign busy_o          = (state_q != StIdle);
    assign sent_count_o    = sent_q;
    assign dropped_count_o = dropped_q;

endmodule

// File: tb/tb_noc_traffic_source.sv
// Bench for noc_traffic_source: directed checks on an always-inject instance (A) and a
// randomized run of a second instance (B) against a queue-based reference model.
module tb_noc_traffic_source;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        send_a, ready_a, valid_a, busy_a;
    logic [31:0] rand_a;
    logic [15:0] data_a, sent_a, drop_a;

    logic        send_b, ready_b, valid_b, busy_b;
    logic [31:0] rand_b;
    logic [15:0] data_b, sent_b, drop_b;

    noc_traffic_source #(
        .ADDR_BITS(4), .SRC_ADDR(0), .INJ_THRESHOLD(256), .FIFO_DEPTH(4), .CNT_BITS(16)
    ) dut_a (
        .clk(clk), .reset(reset), .send_i(send_a), .rand_i(rand_a),
        .out_data_o(data_a), .out_valid_o(valid_a), .out_ready_i(ready_a),
        .busy_o(busy_a), .sent_count_o(sent_a), .dropped_count_o(drop_a)
    );

    noc_traffic_source #(
        .ADDR_BITS(4), .SRC_ADDR(5), .INJ_THRESHOLD(100), .FIFO_DEPTH(4), .CNT_BITS(16)
    ) dut_b (
        .clk(clk), .reset(reset), .send_i(send_b), .rand_i(rand_b),
        .out_data_o(data_b), .out_valid_o(valid_b), .out_ready_i(ready_b),
        .busy_o(busy_b), .sent_count_o(sent_b), .dropped_count_o(drop_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model for instance B: 0 idle, 1 active, 2 drain.
    logic [15:0] mq[$];
    int m_state, m_seq, m_sent, m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_seq   = 0;
        m_sent  = 0;
        m_drop  = 0;
    endtask

    task automatic model_step();
        int n;
        bit pop, gen, empty_after;
        logic [3:0] d;
        n   = mq.size();
        pop = (n != 0) && ready_b;
        gen = (m_state == 1) && send_b && (rand_b[7:0] < 100);
        d   = rand_b[11:8];
        if (d == 4'd5) d = 4'd6;
        if (pop) begin
            void'(mq.pop_front());
            if (m_sent < 65535) m_sent++;
        end
        if (gen) begin
            if (n < 4 || pop) mq.push_back({d, 4'd5, 8'(m_seq)});
            else if (m_drop < 65535) m_drop++;
            m_seq = (m_seq + 1) % 256;
        end
        empty_after = (mq.size() == 0);
        case (m_state)
            0: if (send_b) m_state = 1;
            1: if (!send_b) m_state = (n != 0) ? 2 : 0;
            default: begin
                if (send_b) m_state = 1;
                else if (empty_after) m_state = 0;
            end
        endcase
    endtask

    task automatic check_b();
        check("b_valid", valid_b, mq.size() != 0);
        if (mq.size() != 0) check("b_data", data_b, mq[0]);
        check("b_busy", busy_b, m_state != 0);
        check("b_sent", sent_b, m_sent);
        check("b_drop", drop_b, m_drop);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        check_b();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        send_a = 0; ready_a = 0; rand_a = 0;
        send_b = 0; ready_b = 0; rand_b = 0;
        model_reset();
        #2;
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_sent", sent_a, 0);
        check("rst_drop", drop_a, 0);
        check_b();
        @(posedge clk); #1;
        reset = 1'b0;

        // Always-inject stream, one flit per cycle once started
        rand_a = 32'h300; ready_a = 1;
        tick(); tick();
        send_a = 1;
        tick();
        check("t1_latency", valid_a, 0);
        tick();
        check("t1_first_valid", valid_a, 1);
        check("t1_first_data", data_a, 16'h3000);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t1_stream", data_a, 16'h3000 + 16'(k));
        end
        check("t1_sent", sent_a, 3);
        check("t1_drop", drop_a, 0);

        // dest equal to own address is redirected
        do_reset();
        rand_a = 32'h0; send_a = 1; ready_a = 1;
        tick(); tick();
        check("t2_data0", data_a, 16'h1000);
        tick();
        check("t2_data1", data_a, 16'h1001);

        // Back-pressure: fill, drop, hold head stable
        do_reset();
        rand_a = 32'h300; ready_a = 0; send_a = 1;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_valid", valid_a, 1);
            check("t3_hold", data_a, 16'h3000);
        end
        check("t3_drop", drop_a, 6);
        check("t3_sent", sent_a, 0);

        // Full FIFO with simultaneous pop and push
        ready_a = 1;
        tick();
        check("t4_sent", sent_a, 1);
        check("t4_drop", drop_a, 6);
        check("t4_head", data_a, 16'h3001);

        // Drain: remaining entries then the seq-10 flit, proving occupancy stayed 4
        send_a = 0;
        tick();
        check("t4_drain_busy", busy_a, 1);
        check("t4_d1", data_a, 16'h3002);
        tick();
        check("t4_d2", data_a, 16'h3003);
        tick();
        check("t4_d3", data_a, 16'h300A);
        check("t4_d3_busy", busy_a, 1);
        tick();
        check("t4_empty", valid_a, 0);
        check("t4_idle", busy_a, 0);
        check("t4_sent_final", sent_a, 5);

        // Reset mid-operation with flits queued
        do_reset();
        send_a = 1; ready_a = 0; rand_a = 32'h300;
        tick();
        for (int k = 0; k < 6; k++) tick();
        ready_a = 1;
        tick();
        check("t6_pre_sent", sent_a, 1);
        check("t6_pre_drop", drop_a, 2);
        ready_a = 0;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_valid", valid_a, 0);
        check("t6_data", data_a, 0);
        check("t6_busy", busy_a, 0);
        check("t6_sent", sent_a, 0);
        check("t6_drop", drop_a, 0);
        check_b();
        tick();
        send_a = 0; ready_a = 1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_emit", valid_a, 0);
        end
        send_a = 1;
        tick(); tick();
        check("t6_restart", data_a, 16'h3000);

        // Instance B: enabled but never under threshold, so nothing generated
        send_b = 1; ready_b = 1;
        for (int k = 0; k < 100; k++) begin
            rand_b = {$urandom} & 32'hFFFF_FF00;
            rand_b[7:0] = 8'(100 + $urandom_range(0, 155));
            tick();
            check("b_never", valid_b, 0);
        end

        // Queue exactly three flits, then drain
        ready_b = 0;
        for (int k = 0; k < 3; k++) begin
            rand_b = {$urandom} & 32'hFFFF_FF00;
            tick();
        end
        send_b = 0; ready_b = 1;
        tick(); tick();
        check("b_drain_busy", busy_b, 1);
        tick();
        check("b_drain_idle", busy_b, 0);
        check("b_drain_sent", sent_b, 3);

        // Randomized traffic with varying back-pressure
        for (int seg = 0; seg < 8; seg++) begin
            for (int k = 0; k < 100; k++) begin
                send_b  = $urandom_range(0, 9) != 0;
                ready_b = $urandom_range(0, 7) < 32'(seg);
                rand_b  = $urandom;
                tick();
            end
        end

        // Final drain, bounded
        send_b = 0; ready_b = 1;
        for (int k = 0; k < 20 && (busy_b || valid_b); k++) tick();
        check("b_final_idle", busy_b, 0);
        check("b_final_empty", valid_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/noc_traffic_source.md
Name: noc_traffic_source

Overview:
Synthetic traffic injector for the NoC simulation environment. It sits directly downstream of the stimulus generator and random-number source, and directly upstream of a router's local injection port. Each cycle it uses the `send` enable and a random word to decide whether to create a flit. Created flits are queued in a small FIFO and delivered over a valid/ready handshake. The block keeps sent and dropped counts for end-of-run statistics.

Parameters:
- ADDR_BITS, 4, width of node address; 2^ADDR_BITS nodes.
- SRC_ADDR, 0, this node's address; inserted in every flit.
- INJ_THRESHOLD, 32, 9-bit value in 0..256; injection probability is INJ_THRESHOLD/256; 0 = never, 256 = every cycle.
- FIFO_DEPTH, 4, queue entries; power of 2, 2..16.
- CNT_BITS, 16, width of statistics counters.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high.
- send, in, 1, injection enable from the stimulus generator.
- rand, in, 32, fresh random word every cycle.
- out_data, out, 2*ADDR_BITS+8, flit {dest, src, seq} with dest in the MSBs.
- out_valid, out, 1, flit at FIFO head is valid.
- out_ready, in, 1, downstream accepts the flit.
- busy, out, 1, state != IDLE.
- sent_count, out, CNT_BITS, flits accepted downstream.
- dropped_count, out, CNT_BITS, flits lost because the FIFO was full.

Behaviour:
- Reset (async): state IDLE; FIFO empty with pointers 0; storage 0; seq 0; out_valid 0; out_data 0; busy 0; both counters 0.
- FSM, registered, evaluated each cycle:
  - IDLE -> ACTIVE when send=1.
  - ACTIVE -> DRAIN when send=0 and FIFO not empty.
  - ACTIVE -> IDLE when send=0 and FIFO empty.
  - DRAIN -> ACTIVE when send=1.
  - DRAIN -> IDLE when the FIFO is empty after this cycle's pop.
- Generate event: state==ACTIVE and send==1 and rand[7:0] < INJ_THRESHOLD (9-bit unsigned compare). No generation occurs in IDLE or DRAIN, so the first generation is possible one cycle after send rises.
- Flit fields:
  - dest = rand[8+ADDR_BITS-1:8]; if dest==SRC_ADDR, use dest+1 mod 2^ADDR_BITS (no self-traffic).
  - src = SRC_ADDR.
  - seq = current seq register.
- seq increments by 1 (mod 256) on every generate event, whether the flit is queued or dropped.
- Push/pop rules:
  - Push: generate event and (FIFO not full, or pop in the same cycle).
  - Pop: out_valid & out_ready.
  - Generate while full with no pop: flit discarded; dropped_count += 1, saturating at all-ones.
- Full + simultaneous pop + push: push accepted, occupancy unchanged, no drop.
- Empty + push: out_valid=1 the next cycle (1-cycle latency). Write-through bypass is forbidden.
- out_data = FIFO head, driven from registered storage. It must hold stable while out_valid=1 and out_ready=0.
- out_valid must not deassert without a pop.
- sent_count += 1 on each pop, saturating at all-ones.
- Pointers wrap modulo FIFO_DEPTH. Full/empty is tracked with an occupancy counter 0..FIFO_DEPTH.
- Reset asserted mid-operation: queued flits are discarded and counters cleared immediately; no flit is emitted during reset.
- out_ready is ignored when out_valid=0.

Test Plan:
1. INJ_THRESHOLD=256, SRC_ADDR=0, rand=0x00000300, out_ready=1, send=1 from cycle 3 -> flits 0x3000, 0x3001, 0x3002... one per cycle, first valid 2 cycles after send rises; dropped_count stays 0.
2. Same setup but rand=0x00000000 (dest equals SRC_ADDR) -> dest field = 1, giving out_data 0x1000, 0x1001, ...
3. INJ_THRESHOLD=256, FIFO_DEPTH=4, out_ready=0 for 10 generating cycles -> out_valid=1, occupancy 4, dropped_count=6, head out_data=0x3000 held stable; seq reaches 10.
4. Full FIFO with out_ready=1 in a generating cycle -> sent_count +1, dropped_count unchanged, occupancy stays 4.
5. INJ_THRESHOLD=0, send=1 for 100 cycles -> out_valid never asserts and seq stays 0. Then drop send with 3 flits queued -> busy=1 in DRAIN, IDLE the cycle after the last pop, sent_count=3.
6. Assert reset with 3 flits queued -> out_valid=0, sent_count=0, dropped_count=0 and busy=0 during reset, with no flit emitted after release until a new generate event.
